// File: rtl/mem_port_arbiter.sv
// Single memory port shared between instruction fetch and data requesters, with a response watchdog.
// Define MEM_PORT_ARBITER_RR_EN for round-robin arbitration; otherwise D has fixed priority over IF.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned RESP_TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic                if_err_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic                d_err_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = (RESP_TIMEOUT > 0) ? $clog2(RESP_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(RESP_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t           state, state_nxt;
  logic             owner_d;
  logic [CNT_W-1:0] cnt;
  logic             take_d;
  logic             capture;
  logic             wd_hit;
  logic             resp_ok;
  logic             resp_to;

`ifdef MEM_PORT_ARBITER_RR_EN
  logic last_d;

  always_comb take_d = d_req_i && (!if_req_i || !last_d);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      last_d <= 1'b0;
    end else if (capture) begin
      last_d <= take_d;
    end
  end
`else
  always_comb take_d = d_req_i;
`endif

  // Grants are combinational, so they are also masked while reset is held.
  always_comb begin
    capture  = reset_ni && (state == IDLE) && (if_req_i || d_req_i);
    if_gnt_o = capture && !take_d;
    d_gnt_o  = capture && take_d;
    wd_hit   = (RESP_TIMEOUT != 0) && (cnt == TO_VAL);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    resp_ok   = 1'b0;
    resp_to   = 1'b0;
    case (state)
      IDLE: begin
        if (capture) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (mem_gnt_i) state_nxt = WAIT;
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          resp_ok   = 1'b1;
          state_nxt = IDLE;
        end else if (wd_hit) begin
          resp_to   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req_o   = (state == ISSUE);
    if_rvalid_o = (resp_ok || resp_to) && !owner_d;
    d_rvalid_o  = (resp_ok || resp_to) && owner_d;
    if_err_o    = resp_to && !owner_d;
    d_err_o     = resp_to && owner_d;
    rdata_o     = resp_ok ? mem_rdata_i : '0;
  end

  // Instruction fetches are issued as full-word reads.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      owner_d     <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else if (capture) begin
      owner_d <= take_d;
      if (take_d) begin
        mem_we_o    <= d_we_i;
        mem_be_o    <= d_be_i;
        mem_addr_o  <= d_addr_i;
        mem_wdata_o <= d_wdata_i;
      end else begin
        mem_we_o    <= 1'b0;
        mem_be_o    <= {BE_W{1'b1}};
        mem_addr_o  <= if_addr_i;
        mem_wdata_o <= '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt <= '0;
    end else if (state == ISSUE && mem_gnt_i) begin
      cnt <= '0;
    end else if (state == WAIT && !mem_rvalid_i && cnt != '1) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector tables, hand-written timeout/reset sequences,
// and randomized traffic checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int RT = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .RESP_TIMEOUT(RT)
  ) dut (
    .clk_i(clk), .reset_ni(reset_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_err_o(if_err),
    .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr),
    .d_wdata_i(d_wdata), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_err_o(d_err),
    .rdata_o(rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
  } in_t;

  typedef struct {
    logic        if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input out_t e);
    chk({tag, ".if_gnt"},    32'(if_gnt),    32'(e.if_gnt));
    chk({tag, ".if_rvalid"}, 32'(if_rvalid), 32'(e.if_rvalid));
    chk({tag, ".if_err"},    32'(if_err),    32'(e.if_err));
    chk({tag, ".d_gnt"},     32'(d_gnt),     32'(e.d_gnt));
    chk({tag, ".d_rvalid"},  32'(d_rvalid),  32'(e.d_rvalid));
    chk({tag, ".d_err"},     32'(d_err),     32'(e.d_err));
    chk({tag, ".rdata"},     rdata,          e.rdata);
    chk({tag, ".mem_req"},   32'(mem_req),   32'(e.mem_req));
    chk({tag, ".mem_we"},    32'(mem_we),    32'(e.mem_we));
    chk({tag, ".mem_be"},    32'(mem_be),    32'(e.mem_be));
    chk({tag, ".mem_addr"},  mem_addr,       e.mem_addr);
    chk({tag, ".mem_wdata"}, mem_wdata,      e.mem_wdata);
  endtask

  function automatic in_t mk_in(input logic ir, input logic [31:0] ia, input logic dr,
                                input logic dw, input logic [3:0] db, input logic [31:0] da,
                                input logic [31:0] dd, input logic mg, input logic mv,
                                input logic [31:0] md);
    in_t v;
    v.if_req = ir; v.if_addr = ia; v.d_req = dr; v.d_we = dw; v.d_be = db;
    v.d_addr = da; v.d_wdata = dd; v.mem_gnt = mg; v.mem_rvalid = mv; v.mem_rdata = md;
    return v;
  endfunction

  // flags = {if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err}
  function automatic out_t mk_out(input logic [5:0] flags, input logic [31:0] rd,
                                  input logic mr, input logic mw, input logic [3:0] mb,
                                  input logic [31:0] ma, input logic [31:0] mwd);
    out_t o;
    {o.if_gnt, o.if_rvalid, o.if_err, o.d_gnt, o.d_rvalid, o.d_err} = flags;
    o.rdata = rd; o.mem_req = mr; o.mem_we = mw; o.mem_be = mb;
    o.mem_addr = ma; o.mem_wdata = mwd;
    return o;
  endfunction

  function automatic vec_t mk_vec(input in_t i, input out_t o);
    vec_t v;
    v.i = i; v.o = o;
    return v;
  endfunction

  task automatic apply(input in_t v);
    if_req = v.if_req; if_addr = v.if_addr;
    d_req = v.d_req; d_we = v.d_we; d_be = v.d_be; d_addr = v.d_addr; d_wdata = v.d_wdata;
    mem_gnt = v.mem_gnt; mem_rvalid = v.mem_rvalid; mem_rdata = v.mem_rdata;
  endtask

  task automatic do_reset();
    apply(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Transaction-level reference: at most one outstanding transaction, tracked by
  // whether it has been accepted by memory and how many response cycles have elapsed.
  bit          m_busy, m_acc, m_own_d, m_last_d;
  int          m_waited;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata;

  task automatic model_reset();
    m_busy = 0; m_acc = 0; m_own_d = 0; m_last_d = 0; m_waited = 0;
    m_we = 0; m_be = 0; m_addr = 0; m_wdata = 0;
  endtask

  function automatic bit model_pick_d();
`ifdef MEM_PORT_ARBITER_RR_EN
    if (d_req && if_req) return !m_last_d;
    return d_req;
`else
    return d_req;
`endif
  endfunction

  function automatic bit model_timed_out();
    return (RT != 0) && (m_waited == RT);
  endfunction

  function automatic out_t model_out();
    out_t o;
    o = mk_out(6'b0, 32'h0, 1'b0, m_we, m_be, m_addr, m_wdata);
    if (!m_busy) begin
      if (d_req || if_req) begin
        if (model_pick_d()) o.d_gnt = 1'b1;
        else                o.if_gnt = 1'b1;
      end
    end else if (!m_acc) begin
      o.mem_req = 1'b1;
    end else if (mem_rvalid || model_timed_out()) begin
      if (m_own_d) begin o.d_rvalid = 1'b1;  o.d_err = !mem_rvalid;  end
      else         begin o.if_rvalid = 1'b1; o.if_err = !mem_rvalid; end
      o.rdata = mem_rvalid ? mem_rdata : 32'h0;
    end
    return o;
  endfunction

  task automatic model_step();
    bit pd;
    if (!m_busy) begin
      if (d_req || if_req) begin
        pd = model_pick_d();
        m_busy = 1; m_acc = 0; m_own_d = pd; m_last_d = pd;
        if (pd) begin
          m_we = d_we; m_be = d_be; m_addr = d_addr; m_wdata = d_wdata;
        end else begin
          m_we = 0; m_be = 4'hF; m_addr = if_addr; m_wdata = 0;
        end
      end
    end else if (!m_acc) begin
      if (mem_gnt) begin m_acc = 1; m_waited = 0; end
    end else if (mem_rvalid || model_timed_out()) begin
      m_busy = 0; m_acc = 0;
    end else begin
      m_waited++;
    end
  endtask

  vec_t vecs[$];
  out_t zero_o;

  initial begin
    zero_o = mk_out(6'b0, 0, 0, 0, 4'h0, 0, 0);
    reset_n = 1'b0;
    apply(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    check_out("reset", zero_o);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // IF-only read at 0x100, grant in first ISSUE cycle, data two cycles after the grant.
    vecs.push_back(mk_vec(mk_in(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0),
                          mk_out(6'b100000, 0, 0, 0, 4'h0, 0, 0)));
    vecs.push_back(mk_vec(mk_in(0, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0),
                          mk_out(6'b000000, 0, 1, 0, 4'hF, 32'h100, 0)));
    vecs.push_back(mk_vec(mk_in(0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0),
                          mk_out(6'b000000, 0, 0, 0, 4'hF, 32'h100, 0)));
    vecs.push_back(mk_vec(mk_in(0, 32'h100, 0, 0, 0, 0, 0, 0, 1, 32'h1234_5678),
                          mk_out(6'b010000, 32'h1234_5678, 0, 0, 4'hF, 32'h100, 0)));
    vecs.push_back(mk_vec(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                          mk_out(6'b000000, 0, 0, 0, 4'hF, 32'h100, 0)));
    // Simultaneous IF read (0x300) and D write: D first, IF after D's response.
    vecs.push_back(mk_vec(mk_in(1, 32'h300, 1, 1, 4'b0011, 32'h200, 32'hCAFE_F00D, 0, 0, 0),
                          mk_out(6'b000100, 0, 0, 0, 4'hF, 32'h100, 0)));
    vecs.push_back(mk_vec(mk_in(1, 32'h300, 0, 1, 4'b0011, 32'h200, 32'hCAFE_F00D, 1, 0, 0),
                          mk_out(6'b000000, 0, 1, 1, 4'b0011, 32'h200, 32'hCAFE_F00D)));
    vecs.push_back(mk_vec(mk_in(1, 32'h300, 0, 0, 0, 0, 0, 0, 1, 32'h5555_AAAA),
                          mk_out(6'b000010, 32'h5555_AAAA, 0, 1, 4'b0011, 32'h200, 32'hCAFE_F00D)));
    vecs.push_back(mk_vec(mk_in(1, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0),
                          mk_out(6'b100000, 0, 0, 1, 4'b0011, 32'h200, 32'hCAFE_F00D)));
    // Five stalled ISSUE cycles; a stray rvalid during ISSUE must be ignored.
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk_vec(mk_in(0, 32'h300, 0, 0, 0, 0, 0, 0, (k == 2), 32'hDEAD_BEEF),
                            mk_out(6'b000000, 0, 1, 0, 4'hF, 32'h300, 0)));
    vecs.push_back(mk_vec(mk_in(0, 32'h300, 0, 0, 0, 0, 0, 1, 0, 0),
                          mk_out(6'b000000, 0, 1, 0, 4'hF, 32'h300, 0)));
    vecs.push_back(mk_vec(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0BAD_F00D),
                          mk_out(6'b010000, 32'h0BAD_F00D, 0, 0, 4'hF, 32'h300, 0)));
    vecs.push_back(mk_vec(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                          mk_out(6'b000000, 0, 0, 0, 4'hF, 32'h300, 0)));

    foreach (vecs[n]) begin
      apply(vecs[n].i);
      @(negedge clk);
      check_out($sformatf("vec%0d", n), vecs[n].o);
      @(posedge clk);
      #1;
    end

    // Watchdog: D read at 0x400 granted, memory never answers.
    apply(mk_in(0, 0, 1, 0, 4'hF, 32'h400, 0, 0, 0, 0));
    @(negedge clk); check_out("to_cap", mk_out(6'b000100, 0, 0, 0, 4'hF, 32'h300, 0));
    @(posedge clk); #1;
    apply(mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    @(negedge clk); check_out("to_issue", mk_out(6'b000000, 0, 1, 0, 4'hF, 32'h400, 0));
    @(posedge clk); #1;
    for (int k = 0; k < RT; k++) begin
      apply(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF));
      @(negedge clk); check_out($sformatf("to_wait%0d", k), mk_out(6'b0, 0, 0, 0, 4'hF, 32'h400, 0));
      @(posedge clk); #1;
    end
    @(negedge clk); check_out("to_err", mk_out(6'b000011, 0, 0, 0, 4'hF, 32'h400, 0));
    @(posedge clk); #1;
    apply(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1234_5678));
    @(negedge clk); check_out("to_late", mk_out(6'b0, 0, 0, 0, 4'hF, 32'h400, 0));
    @(posedge clk); #1;

    // Asynchronous reset while waiting for a response.
    apply(mk_in(1, 32'h500, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    apply(mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    @(posedge clk); #1;
    apply(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("rst_pre.mem_addr", mem_addr, 32'h500);
    #1 reset_n = 1'b0;
    #1 check_out("rst_async", zero_o);
    @(posedge clk); #1 reset_n = 1'b1;
    apply(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA5A5_A5A5));
    @(negedge clk); check_out("rst_stray", zero_o);
    @(posedge clk); #1;

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 800; c++) begin
      if (!if_req) begin
        if ($urandom_range(0, 2) == 0) begin if_req = 1'b1; if_addr = $urandom; end
      end else if ($urandom_range(0, 15) == 0) begin
        if_req = 1'b0;
      end
      if (!d_req) begin
        if ($urandom_range(0, 2) == 0) begin
          d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom);
          d_addr = $urandom; d_wdata = $urandom;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        d_req = 1'b0;
      end
      mem_gnt    = 1'($urandom_range(0, 1));
      mem_rvalid = ($urandom_range(0, 4) == 0);
      mem_rdata  = $urandom;
      @(negedge clk);
      check_out("rand", model_out());
      model_step();
      @(posedge clk);
      #1;
      if (if_gnt) if_req = 1'b0;
      if (d_gnt)  d_req = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
